// File: rtl/tx_iq_pacer.sv
// Paces IQ samples from the TX baseband into a DAC at one sample per CLK_DIV clocks.
// A prefill threshold absorbs upstream jitter; an empty FIFO mid-packet emits zeros and flags underrun.
module tx_iq_pacer #(
  parameter int DEPTH   = 64,
  parameter int CLK_DIV = 10,
  parameter int PREFILL = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_i,
  input  logic [15:0]              in_q,
  input  logic                     pkt_done,
  output logic                     dac_valid,
  output logic [31:0]              dac_data,
  output logic                     underrun,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [FW-1:0] FULL_LVL    = FW'(DEPTH);
  localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFILL,
    S_STREAM
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [FW-1:0]   r_fill;
  logic [DW-1:0]   r_div_cnt;
  logic [DW-1:0]   w_div_next;
  logic            r_done_latch;
  logic            w_done_next;
  logic            r_dac_valid;
  logic [31:0]     r_dac_data;
  logic            r_underrun;

  logic            w_in_ready;
  logic            w_push;
  logic            w_empty;
  logic            w_strobe;
  logic            w_pop;
  logic            w_zero_out;
  logic            w_end;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign w_in_ready = (r_fill < FULL_LVL);
  assign w_push     = in_valid && w_in_ready;
  assign w_empty    = (r_fill == '0);
  assign w_strobe   = (r_state == S_STREAM) && (r_div_cnt == '0);
  assign w_pop      = w_strobe && !w_empty;
  assign w_zero_out = w_strobe && w_empty && !r_done_latch;
  assign w_end      = w_strobe && w_empty && r_done_latch;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = r_done_latch;
    w_div_next   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_push) w_state_next = S_PREFILL;
      end
      S_PREFILL: begin
        if (pkt_done) w_done_next = 1'b1;
        if ((r_fill >= PREFILL_LVL) || ((r_done_latch || pkt_done) && !w_empty))
          w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (pkt_done) w_done_next = 1'b1;
        if (w_end) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b0;
        end else begin
          w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_div_cnt    <= '0;
      r_done_latch <= 1'b0;
      r_dac_valid  <= 1'b0;
      r_dac_data   <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_div_cnt    <= w_div_next;
      r_done_latch <= w_done_next;
      r_dac_valid  <= w_pop || w_zero_out;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
      if (w_pop)           r_dac_data <= r_mem[r_rd_ptr];
      else if (w_zero_out) r_dac_data <= '0;
      if (w_zero_out) r_underrun <= 1'b1;
    end
  end

  // NOTE: the sample store has no reset; pointers and fill level alone define valid contents.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_i, in_q};
  end

  assign in_ready   = w_in_ready;
  assign dac_valid  = r_dac_valid;
  assign dac_data   = r_dac_data;
  assign underrun   = r_underrun;
  assign busy       = (r_state != S_IDLE);
  assign fill_level = r_fill;

endmodule

// File: tb/tb_tx_iq_pacer.sv
// Bench for tx_iq_pacer: two instances (default and small/fast) checked every cycle
// against a queue-based transaction model, plus literal checks for the key scenarios.
module tb_tx_iq_pacer;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        vld   [2];
  logic        rdy   [2];
  logic [15:0] di    [2];
  logic [15:0] dq    [2];
  logic        pdone [2];
  logic        dv    [2];
  logic [31:0] dd    [2];
  logic        und   [2];
  logic        bsy   [2];
  logic [6:0]  fill0;
  logic [2:0]  fill1;

  always #5 clock = ~clock;

  tx_iq_pacer #(.DEPTH(64), .CLK_DIV(10), .PREFILL(16)) u_dut0 (
    .clock(clock), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_i(di[0]), .in_q(dq[0]), .pkt_done(pdone[0]), .dac_valid(dv[0]),
    .dac_data(dd[0]), .underrun(und[0]), .busy(bsy[0]), .fill_level(fill0)
  );

  tx_iq_pacer #(.DEPTH(4), .CLK_DIV(2), .PREFILL(4)) u_dut1 (
    .clock(clock), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_i(di[1]), .in_q(dq[1]), .pkt_done(pdone[1]), .dac_valid(dv[1]),
    .dac_data(dd[1]), .underrun(und[1]), .busy(bsy[1]), .fill_level(fill1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit armed   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d] cyc=%0d got=%h expected=%h", name, k, cyc, act, exp);
    end
  endtask

  // Model: queue of buffered samples, mode (0 idle, 1 prefill, 2 stream), cycles spent streaming.
  int          P_DEPTH [2] = '{64, 4};
  int          P_DIV   [2] = '{10, 2};
  int          P_PRE   [2] = '{16, 4};
  logic [31:0] m_buf   [2][256];
  int          m_head  [2] = '{0, 0};
  int          m_tail  [2] = '{0, 0};
  int          m_mode  [2] = '{0, 0};
  int          m_age   [2] = '{0, 0};
  bit          m_done  [2] = '{0, 0};
  bit          m_und   [2] = '{0, 0};
  bit          m_valid [2] = '{0, 0};
  logic [31:0] m_data  [2] = '{0, 0};

  task automatic model_step(input int k);
    int size;
    bit push;
    size = m_tail[k] - m_head[k];
    if (rst) begin
      m_head[k] = 0; m_tail[k] = 0; m_mode[k] = 0; m_age[k] = 0;
      m_done[k] = 0; m_und[k] = 0; m_valid[k] = 0; m_data[k] = '0;
      return;
    end
    push = vld[k] && (size < P_DEPTH[k]);
    m_valid[k] = 0;
    case (m_mode[k])
      0: if (push) m_mode[k] = 1;
      1: begin
        if (pdone[k]) m_done[k] = 1;
        if (size >= P_PRE[k] || (m_done[k] && size > 0)) begin
          m_mode[k] = 2;
          m_age[k]  = 0;
        end
      end
      default: begin
        if (m_age[k] % P_DIV[k] == 0) begin
          if (size > 0) begin
            m_data[k]  = m_buf[k][m_head[k] % 256];
            m_head[k]++;
            m_valid[k] = 1;
          end else if (!m_done[k]) begin
            m_und[k]   = 1;
            m_valid[k] = 1;
            m_data[k]  = '0;
          end else begin
            m_mode[k] = 0;
            m_done[k] = 0;
          end
        end
        if (m_mode[k] == 2) begin
          if (pdone[k]) m_done[k] = 1;
          m_age[k]++;
        end
      end
    endcase
    if (push) begin
      m_buf[k][m_tail[k] % 256] = {di[k], dq[k]};
      m_tail[k]++;
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
    if (rst) armed = 1;
    cyc++;
  end

  // Per-run statistics gathered from the DUT outputs.
  int          out_cnt  [2];
  int          zero_cnt [2];
  int          real_cnt [2];
  int          first_dv [2];
  int          last_dv  [2] = '{-1, -1};
  int          max_fill [2];
  logic [31:0] first_out[2];
  logic [31:0] last_out [2];
  bit          saw_full = 0;
  int          t_push16 = 0;

  always @(negedge clock) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        int size;
        int fl;
        size = m_tail[k] - m_head[k];
        fl   = (k == 0) ? int'(fill0) : int'(fill1);
        check("dac_valid",  k, 32'(dv[k]),  32'(m_valid[k]));
        check("dac_data",   k, dd[k],       m_data[k]);
        check("underrun",   k, 32'(und[k]), 32'(m_und[k]));
        check("busy",       k, 32'(bsy[k]), 32'(m_mode[k] != 0));
        check("fill_level", k, 32'(fl),     32'(size));
        check("in_ready",   k, 32'(rdy[k]), 32'(size < P_DEPTH[k]));
        if (fl > max_fill[k]) max_fill[k] = fl;
        if (k == 0 && !rdy[0] && fl == 64) saw_full = 1;
        if (dv[k]) begin
          if (last_dv[k] >= 0) check("spacing", k, 32'(cyc - last_dv[k]), 32'(P_DIV[k]));
          last_dv[k] = cyc;
          if (first_dv[k] < 0) begin
            first_dv[k]  = cyc;
            first_out[k] = dd[k];
          end
          last_out[k] = dd[k];
          out_cnt[k]++;
          if (dd[k] == '0) zero_cnt[k]++;
          else             real_cnt[k]++;
        end
        if (m_mode[k] == 0) last_dv[k] = -1;
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      out_cnt[k] = 0; zero_cnt[k] = 0; real_cnt[k] = 0;
      first_dv[k] = -1; max_fill[k] = 0;
      first_out[k] = '0; last_out[k] = '0;
    end
    saw_full = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 0; pdone[k] = 0;
    end
    @(negedge clock);
    rst = 0;
    clear_stats();
  endtask

  task automatic send(input int k, input int n, input int base, input bit gaps, input bit rnd_data);
    int idx   = 0;
    int guard = 0;
    while (idx < n && guard < 20000) begin
      @(negedge clock);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        vld[k] = 0;
      end else begin
        vld[k] = 1;
        if (rnd_data) begin
          di[k] = 16'($urandom);
          dq[k] = 16'($urandom);
        end else begin
          di[k] = 16'(base + idx);
          dq[k] = 16'(-(base + idx));
        end
        if (rdy[k]) begin
          idx++;
          if (idx == 16) t_push16 = cyc + 1;
        end
      end
    end
    if (idx < n) check("send_timeout", k, 32'(idx), 32'(n));
    @(negedge clock);
    vld[k] = 0;
  endtask

  task automatic pulse_done(input int k);
    @(negedge clock);
    pdone[k] = 1;
    @(negedge clock);
    pdone[k] = 0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while (bsy[k] && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 5000) check("idle_timeout", k, 32'(bsy[k]), 32'(0));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      vld[k] = 0; pdone[k] = 0; di[k] = '0; dq[k] = '0;
    end
    clear_stats();
    repeat (2) @(negedge clock);
    check("reset_fill",      0, 32'(fill0),  32'(0));
    check("reset_in_ready",  0, 32'(rdy[0]), 32'(1));
    check("reset_dac_valid", 0, 32'(dv[0]),  32'(0));
    check("reset_dac_data",  0, dd[0],       32'(0));
    check("reset_underrun",  0, 32'(und[0]), 32'(0));
    check("reset_busy",      0, 32'(bsy[0]), 32'(0));
    rst = 0;

    // 100 back-to-back samples, i = n, q = -n.
    do_reset();
    send(0, 100, 1, 0, 0);
    pulse_done(0);
    wait_idle(0);
    check("first_out_latency", 0, 32'(first_dv[0] - t_push16), 32'(2));
    check("out_count_100",     0, 32'(out_cnt[0]), 32'(100));
    check("first_sample",      0, first_out[0], 32'h0001_FFFF);
    check("last_sample",       0, last_out[0],  32'h0064_FF9C);
    check("no_underrun",       0, 32'(und[0]),  32'(0));

    // 70 samples: FIFO must fill exactly to 64 and drop in_ready there.
    do_reset();
    send(0, 70, 1, 0, 0);
    pulse_done(0);
    wait_idle(0);
    check("max_fill_64",   0, 32'(max_fill[0]), 32'(64));
    check("ready_low_full", 0, 32'(saw_full),   32'(1));
    check("out_count_70",  0, 32'(out_cnt[0]),  32'(70));
    check("last_sample_70", 0, last_out[0],     32'h0046_FFBA);

    // Stall without pkt_done: underrun with zero pulses, then recovery.
    do_reset();
    send(0, 20, 1, 0, 0);
    wait_cycles(300);
    check("underrun_set",  0, 32'(und[0]), 32'(1));
    check("zero_pulses",   0, 32'(zero_cnt[0] >= 5), 32'(1));
    clear_stats();
    send(0, 10, 1000, 0, 0);
    pulse_done(0);
    wait_idle(0);
    check("resume_real",   0, 32'(real_cnt[0]), 32'(10));
    check("underrun_stky", 0, 32'(und[0]), 32'(1));

    // Short packet ended during prefill.
    do_reset();
    send(0, 5, 1, 0, 0);
    pulse_done(0);
    wait_idle(0);
    check("short_count",   0, 32'(out_cnt[0]), 32'(5));
    check("short_last",    0, last_out[0], 32'h0005_FFFB);

    // Reset with 30 samples buffered while streaming.
    do_reset();
    send(0, 32, 1, 0, 0);
    check("buffered_30",   0, 32'(fill0), 32'(30));
    do_reset();
    check("rst_fill",      0, 32'(fill0),  32'(0));
    check("rst_dac_valid", 0, 32'(dv[0]),  32'(0));
    check("rst_busy",      0, 32'(bsy[0]), 32'(0));
    check("rst_underrun",  0, 32'(und[0]), 32'(0));
    send(0, 16, 200, 0, 0);
    pulse_done(0);
    wait_idle(0);
    check("post_rst_count", 0, 32'(out_cnt[0]), 32'(16));

    // Random packets with random gaps and data on the default instance.
    for (int p = 0; p < 6; p++) begin
      send(0, $urandom_range(1, 90), 0, 1, 1);
      pulse_done(0);
      wait_idle(0);
    end

    // Small, fast instance: wrap-around over 50 samples at 2-cycle spacing.
    do_reset();
    send(1, 50, 1, 0, 0);
    pulse_done(1);
    wait_idle(1);
    check("small_count",    1, 32'(out_cnt[1]),  32'(50));
    check("small_last",     1, last_out[1],      32'h0032_FFCE);
    check("small_max_fill", 1, 32'(max_fill[1]), 32'(4));
    check("small_underrun", 1, 32'(und[1]),      32'(0));
    for (int p = 0; p < 4; p++) begin
      send(1, $urandom_range(1, 40), 0, 1, 1);
      pulse_done(1);
      wait_idle(1);
    end

    wait_cycles(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
